// File: rtl/wb_slave_mem.sv
// Wishbone slave with a word-addressed RAM: classic cycles, incrementing bursts and programmable wait states.
// Optional macro WB_SLAVE_ERR_EN adds wb_err_o for addresses beyond the memory range.
module wb_slave_mem #(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        wb_clk_i,
    input  logic        RESETN,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_addr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [2:0]  wb_cti_i,
`ifdef WB_SLAVE_ERR_EN
    output logic        wb_err_o,
`endif
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned CW = 3;
    localparam logic [2:0]  CTI_INCR = 3'b010;
    localparam logic [2:0]  CTI_EOB  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_BURST
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [AW-1:0] addr_cnt;
    logic          burst_q;
    logic          err_q;
    logic          err_resp;
    logic [31:0]   mem [MEM_DEPTH];

    logic [AW-1:0] start_idx_c;
    logic          start_err_c;
    logic          start_burst_c;
    logic          bus_c;
    logic          beat_c;
    logic          mem_we_c;
    logic          unused_addr;

    assign start_idx_c = wb_addr_i[AW+1:2];
    assign bus_c       = wb_cyc_i & wb_stb_i;

`ifdef WB_SLAVE_ERR_EN
    assign start_err_c = |wb_addr_i[31:AW+2];
    assign wb_err_o    = err_resp;
    assign unused_addr = ^wb_addr_i[1:0];
`else
    // Upper address bits alias onto the memory in this build.
    assign start_err_c = 1'b0;
    assign unused_addr = ^{wb_addr_i[31:AW+2], wb_addr_i[1:0]};
`endif

    assign start_burst_c = (wb_cti_i == CTI_INCR) & ~start_err_c;

    // A beat is committed on the same edge that registers its acknowledge.
    assign beat_c   = RESETN & bus_c & ((state == S_ACK) | (state == S_BURST));
    assign mem_we_c = beat_c & wb_we_i & ~err_q;

    // Byte-lane write port; contents survive reset.
    always_ff @(posedge wb_clk_i) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    mem[addr_cnt][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    // Transfer FSM with registered ack/err/data.
    always_ff @(posedge wb_clk_i) begin
        if (!RESETN) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            addr_cnt <= '0;
            burst_q  <= 1'b0;
            err_q    <= 1'b0;
            err_resp <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            err_resp <= 1'b0;
            case (state)
                S_IDLE: begin
                    // The stale request seen during the response cycle must not restart a transfer.
                    if (bus_c && !wb_ack_o && !err_resp) begin
                        wait_cnt <= CW'(WAIT_STATES);
                        addr_cnt <= start_idx_c;
                        err_q    <= start_err_c;
                        burst_q  <= start_burst_c;
                        if (WAIT_STATES == 0) begin
                            state <= start_burst_c ? S_BURST : S_ACK;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!wb_cyc_i) begin
                        state    <= S_IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt <= CW'(1)) begin
                        wait_cnt <= '0;
                        state    <= burst_q ? S_BURST : S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_ACK: begin
                    if (!wb_cyc_i) begin
                        state <= S_IDLE;
                    end else if (wb_stb_i) begin
                        if (err_q) begin
                            err_resp <= 1'b1;
                            wb_dat_o <= '0;
                        end else begin
                            wb_ack_o <= 1'b1;
                            if (!wb_we_i) begin
                                wb_dat_o <= mem[addr_cnt];
                            end
                        end
                        state <= S_IDLE;
                    end
                end
                S_BURST: begin
                    if (!wb_cyc_i) begin
                        state <= S_IDLE;
                    end else if (wb_stb_i) begin
                        wb_ack_o <= 1'b1;
                        if (!wb_we_i) begin
                            wb_dat_o <= mem[addr_cnt];
                        end
                        addr_cnt <= addr_cnt + AW'(1);
                        if (wb_cti_i == CTI_EOB) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed bench for wb_slave_mem (MEM_DEPTH=256, WAIT_STATES=1); covers both WB_SLAVE_ERR_EN builds.
module tb_wb_slave_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;
    logic [2:0]  cti = '0;
    logic [31:0] rdat;
    logic        ack;
`ifdef WB_SLAVE_ERR_EN
    logic        err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] bdat [4];
    logic [31:0] brd [4];
    int          back_edge [4];

    wb_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(1)) dut (
        .wb_clk_i  (clk),
        .RESETN    (rst_n),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_addr_i (addr),
        .wb_dat_i  (wdat),
        .wb_sel_i  (sel),
        .wb_cti_i  (cti),
`ifdef WB_SLAVE_ERR_EN
        .wb_err_o  (err),
`endif
        .wb_dat_o  (rdat),
        .wb_ack_o  (ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One classic cycle; lat counts edges from the start sample to the ack edge.
    task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output int lat);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; sel = s; cti = 3'b000;
        lat = -1;
        rd  = '0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = e;
                rd  = rdat;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("ack_gap", 32'(ack), 32'(0));
    endtask

    // Incrementing burst of n beats from bdat; optional stb stall after stall_after beats.
    task automatic burst(input logic w, input logic [31:0] a, input int n,
                         input int stall_after, input int stall_len);
        int beats;
        int edges;
        int stall_left;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = bdat[0]; sel = 4'hF;
        cti = (n == 1) ? 3'b111 : 3'b010;
        beats = 0; edges = 0; stall_left = 0;
        while (beats < n && edges < 50) begin
            @(posedge clk); #1;
            edges++;
            if (ack) begin
                brd[beats]       = rdat;
                back_edge[beats] = edges;
                beats++;
                if (beats == n) begin
                    cyc = 1'b0; stb = 1'b0; cti = 3'b000; we = 1'b0;
                end else begin
                    wdat = bdat[beats];
                    cti  = (beats == n - 1) ? 3'b111 : 3'b010;
                    if (beats == stall_after) begin
                        stb = 1'b0;
                        stall_left = stall_len;
                    end
                end
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) stb = 1'b1;
            end
        end
        cyc = 1'b0; stb = 1'b0; cti = 3'b000; we = 1'b0;
        check("burst_beats", 32'(beats), 32'(n));
        @(posedge clk); #1;
        check("burst_end_ack", 32'(ack), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        int          cnt;

        vt[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 32'h10,  32'h0,        4'hF, 1'b1, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 32'h20,  32'hAAAAAAAA, 4'hF, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 32'h20,  32'h11223344, 4'h5, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 32'h20,  32'h0,        4'hF, 1'b1, 32'hAA22AA44};
        vt[5]  = '{1'b1, 32'h24,  32'h12345678, 4'hF, 1'b0, 32'h0};
        vt[6]  = '{1'b1, 32'h24,  32'hFFFFFFFF, 4'h0, 1'b0, 32'h0};
        vt[7]  = '{1'b0, 32'h24,  32'h0,        4'h0, 1'b1, 32'h12345678};
        vt[8]  = '{1'b1, 32'h3F8, 32'hFE00FE00, 4'hF, 1'b0, 32'h0};
        vt[9]  = '{1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
        vt[10] = '{1'b1, 32'h00,  32'h00000A00, 4'hF, 1'b0, 32'h0};
        vt[11] = '{1'b1, 32'h04,  32'h01010101, 4'hF, 1'b0, 32'h0};
        vt[12] = '{1'b1, 32'h30,  32'h30303030, 4'hF, 1'b0, 32'h0};
        vt[13] = '{1'b0, 32'h3FC, 32'h0,        4'h2, 1'b1, 32'hCAFEF00D};
        vt[14] = '{1'b1, 32'h50,  32'h50505050, 4'hF, 1'b0, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", 32'(ack), 32'(0));
        check("reset_dat", rdat, 32'h0);
`ifdef WB_SLAVE_ERR_EN
        check("reset_err", 32'(err), 32'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            classic(vt[i].w, vt[i].a, vt[i].d, vt[i].s, rd, lat);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(2));
            if (vt[i].chk) check($sformatf("vec%0d_dat", i), rd, vt[i].exp);
        end

        // Read burst across the top of memory wraps to word 0.
        burst(1'b0, 32'h3F8, 4, 99, 0);
        check("rb_first_edge", 32'(back_edge[0]), 32'(3));
        check("rb_beat0", brd[0], 32'hFE00FE00);
        check("rb_beat1", brd[1], 32'hCAFEF00D);
        check("rb_beat2", brd[2], 32'h00000A00);
        check("rb_beat3", brd[3], 32'h01010101);
        check("rb_consec", 32'(back_edge[3] - back_edge[0]), 32'(3));
        check("rb_dat_hold", rdat, 32'h01010101);

        // Write burst with a two-cycle strobe stall after the second beat.
        bdat[0] = 32'hB0000010; bdat[1] = 32'hB1000011;
        bdat[2] = 32'hB2000012; bdat[3] = 32'hB3000013;
        burst(1'b1, 32'h40, 4, 2, 2);
        check("wb_stall_gap", 32'(back_edge[2] - back_edge[1]), 32'(3));
        check("wb_resume", 32'(back_edge[3] - back_edge[2]), 32'(1));
        for (int i = 0; i < 4; i++) begin
            classic(1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'hF, rd, lat);
            check($sformatf("wb_word%0d", 16 + i), rd, bdat[i]);
        end
        classic(1'b0, 32'h50, 32'h0, 4'hF, rd, lat);
        check("wb_no_overrun", rd, 32'h50505050);

        // Reset during the wait state of a write.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h30; wdat = 32'h0BADF00D; sel = 4'hF; cti = 3'b000;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_ack", 32'(ack), 32'(0));
        check("rst_mid_dat", rdat, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        cnt = 0;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk); #1;
            if (ack) cnt++;
        end
        check("rst_no_ack", 32'(cnt), 32'(0));
        classic(1'b0, 32'h30, 32'h0, 4'hF, rd, lat);
        check("rst_no_write", rd, 32'h30303030);

`ifdef WB_SLAVE_ERR_EN
        begin
            int errs;
            int acks;
            int first;
            @(negedge clk);
            cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h0001_0000; sel = 4'hF; cti = 3'b000;
            errs = 0; acks = 0; first = -1;
            for (int e = 0; e < 6; e++) begin
                @(posedge clk); #1;
                if (err) begin
                    errs++;
                    if (first < 0) first = e;
                    cyc = 1'b0; stb = 1'b0;
                end
                if (ack) acks++;
            end
            cyc = 1'b0; stb = 1'b0;
            check("err_pulses", 32'(errs), 32'(1));
            check("err_no_ack", 32'(acks), 32'(0));
            check("err_lat", 32'(first), 32'(2));
            check("err_dat", rdat, 32'h0);
        end
`else
        classic(1'b0, 32'h0001_0000, 32'h0, 4'hF, rd, lat);
        check("alias_lat", 32'(lat), 32'(2));
        check("alias_dat", rd, 32'h00000A00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_slave_mem.md
WB_SLAVE_MEM -- requirements
Module: wb_slave_mem

Interface
REQ-001 Parameter MEM_DEPTH, default 256, word count (power of two, 16..4096).
REQ-002 Parameter WAIT_STATES, default 1, idle cycles before the first ack of a cycle (0..7).
REQ-003 wb_clk_i  input  1  sole clock, rising edge.
REQ-004 RESETN  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 wb_cyc_i  input  1  bus cycle valid.
REQ-006 wb_stb_i  input  1  transfer strobe.
REQ-007 wb_we_i  input  1  1 = write, 0 = read.
REQ-008 wb_addr_i  input  32  byte address; word index = wb_addr_i[log2(MEM_DEPTH)+1:2].
REQ-009 wb_dat_i  input  32  write data.
REQ-010 wb_sel_i  input  4  byte-lane enables; bit n covers bits [8n+7:8n].
REQ-011 wb_cti_i  input  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst.
REQ-012 wb_dat_o  output  32  registered read data.
REQ-013 wb_ack_o  output  1  registered transfer acknowledge.

Function
REQ-014 FSM states: IDLE, WAIT, ACK, BURST; transfer starts in IDLE when wb_cyc_i & wb_stb_i are sampled high.
REQ-015 Start: load wait counter with WAIT_STATES, latch the word index into the burst address counter, latch cti class; WAIT_STATES=0 goes directly to ACK/BURST.
REQ-016 Classic (start cti 000 or 111): ack high exactly one cycle, WAIT_STATES+1 cycles after the start sample, then IDLE; ack low for at least one cycle between classic transfers.
REQ-017 Burst (start cti 010): after the wait states, BURST acks every cycle while wb_cyc_i & wb_stb_i are high.
REQ-018 Burst beat n uses word index (start + n) mod MEM_DEPTH, from the internal counter; wb_addr_i is ignored after the first beat; the counter wraps from MEM_DEPTH-1 to 0.
REQ-019 Burst end: a beat acked with wb_cti_i = 111 is the last; next state IDLE, ack low the next cycle.
REQ-020 wb_stb_i low in BURST with wb_cyc_i high: ack low, counter holds; beats resume at the held index, no added wait states.
REQ-021 wb_cyc_i low in any non-IDLE state: abort to IDLE next cycle; no ack; no write for that beat.
REQ-022 Write: on each acked beat, update only the lanes selected by wb_sel_i; wb_sel_i = 0000 is still acked and changes nothing.
REQ-023 Read: wb_dat_o presents the full word of the acked beat in the same cycle ack is high; wb_sel_i is ignored.
REQ-024 wb_dat_o holds its last value when ack is low.
REQ-025 A read of a word written in the preceding beat returns the new data.

Reset
REQ-026 While RESETN is low at a wb_clk_i edge: state IDLE, wb_ack_o 0, wb_dat_o 0, counters 0.
REQ-027 Reset mid-transfer: abort at the next edge, no further ack, no partial write.
REQ-028 Memory contents are not reset.

Configuration
REQ-029 Macro WB_SLAVE_ERR_EN defined: add output wb_err_o (1 bit, reset 0).
REQ-030 With WB_SLAVE_ERR_EN, nonzero wb_addr_i[31:log2(MEM_DEPTH)+2] at start: wb_err_o replaces wb_ack_o with the same timing, no write occurs, wb_dat_o = 0, and the cycle ends as classic.
REQ-031 Without the macro: no wb_err_o port; upper address bits are ignored and aliasing occurs.

Verification
REQ-032 Classic write 0xDEADBEEF @0x10, sel 1111, then classic read @0x10 -> ack 2 cycles after stb each, read 0xDEADBEEF.
REQ-033 Write 0x11223344 sel 0101 over 0xAAAAAAAA @0x20 -> read returns 0xAA22AA44.
REQ-034 Read burst 4 beats from word 254 (depth 256), last beat cti 111 -> data of words 254, 255, 0, 1 on consecutive ack cycles, then ack 0.
REQ-035 Write burst, stb low 2 cycles after beat 2 -> ack low 2 cycles; beat 3 written to start+2, no skipped index.
REQ-036 RESETN low during WAIT of a write @0x30 -> no ack; word @0x30 unchanged.
REQ-037 WB_SLAVE_ERR_EN, read @0x0001_0000 -> wb_err_o pulses 1 cycle, wb_ack_o stays 0; without the macro, same address reads word 0.
